// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer
//
// Collects seven raw 8-bit feature beats into one frame. Each beat is
// quantised to 2 bits against three thresholds, and the frame is presented
// as a packed vector on feat_a..feat_g for a ternary classifier stage.
// A frame must end with s_last on exactly its 7th beat. A frame that ends
// early, or that runs past 7 beats, is discarded and frame_err pulses for
// one cycle. Beats that overrun a frame are dropped up to and including
// the next s_last.
//
// Optional feature: define TNN_PACK_ERRCNT_EN to add err_cnt. This is a
// saturating 8-bit count of frame_err pulses.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   s_valid    in   raw feature beat valid
//   s_ready    out  packer accepts beat (state decode, forced low in reset)
//   s_data     in   8-bit unsigned raw feature
//   s_last     in   marks the 7th (final) feature of a frame
//   feat_a..g  out  2-bit quantised features 0..6 (registered)
//   m_valid    out  packed vector valid (registered)
//   m_ready    in   classifier consumes the vector
//   frame_err  out  one-cycle pulse on a malformed frame (registered)
//   err_cnt    out  [TNN_PACK_ERRCNT_EN only] saturating error count

module tnn_feature_packer #(
    parameter logic [7:0] T0 = 8'd64,
    parameter logic [7:0] T1 = 8'd128,
    parameter logic [7:0] T2 = 8'd192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic [1:0] feat_a,
    output logic [1:0] feat_b,
    output logic [1:0] feat_c,
    output logic [1:0] feat_d,
    output logic [1:0] feat_e,
    output logic [1:0] feat_f,
    output logic [1:0] feat_g,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err
`ifdef TNN_PACK_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DROP    = 2'd2
    } state_t;

    // Boundary values map upward: a value equal to a threshold takes the
    // higher code.
    function automatic logic [1:0] quantise(input logic [7:0] v);
        logic [1:0] q;
        if (v >= T2)      q = 2'd3;
        else if (v >= T1) q = 2'd2;
        else if (v >= T0) q = 2'd1;
        else              q = 2'd0;
        return q;
    endfunction

    state_t      r_state;
    logic [2:0]  r_idx;
    // Beats 0..5 of the current frame. The oldest beat sits in the top bits.
    logic [11:0] r_buf;
    // Packed output vector {a,b,c,d,e,f,g}.
    logic [13:0] r_feat;
    logic        r_m_valid;
    logic        r_frame_err;

    logic        w_accept;
    logic [1:0]  w_q;

    // s_ready decodes state only. It is also held low during reset so that
    // no beat appears to be accepted while the packer is being cleared.
    assign s_ready  = !rst && (r_state != HOLD);
    assign w_accept = s_valid && s_ready;
    assign w_q      = quantise(s_data);

    assign feat_a    = r_feat[13:12];
    assign feat_b    = r_feat[11:10];
    assign feat_c    = r_feat[9:8];
    assign feat_d    = r_feat[7:6];
    assign feat_e    = r_feat[5:4];
    assign feat_f    = r_feat[3:2];
    assign feat_g    = r_feat[1:0];
    assign m_valid   = r_m_valid;
    assign frame_err = r_frame_err;

    // Capture buffer. It is data only and is not reset. After a reset the
    // index restarts at 0, and six fresh beats shift through before any
    // load, so stale entries can never reach the outputs.
    always_ff @(posedge clk) begin
        if (r_state == COLLECT && w_accept && !s_last && r_idx != 3'd6)
            r_buf <= {r_buf[9:0], w_q};
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_idx       <= 3'd0;
            r_m_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_feat      <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_idx <= 3'd0;
                            if (r_idx == 3'd6) begin
                                r_feat    <= {r_buf, w_q};
                                r_m_valid <= 1'b1;
                                r_state   <= HOLD;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else if (r_idx == 3'd6) begin
                            // 7th beat without s_last: drop until s_last.
                            r_idx       <= 3'd0;
                            r_frame_err <= 1'b1;
                            r_state     <= DROP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= COLLECT;
                    end
                end
                DROP: begin
                    if (w_accept && s_last) begin
                        r_idx   <= 3'd0;
                        r_state <= COLLECT;
                    end
                end
                default: begin
                    r_idx     <= 3'd0;
                    r_m_valid <= 1'b0;
                    r_state   <= COLLECT;
                end
            endcase
        end
    end

`ifdef TNN_PACK_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts registered frame_err pulses and sticks at 255.
    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= 8'd0;
        else if (r_frame_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_tnn_feature_packer.sv
module tb_tnn_feature_packer;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic [1:0] feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
`ifdef TNN_PACK_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    tnn_feature_packer dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .feat_a   (feat_a),
        .feat_b   (feat_b),
        .feat_c   (feat_c),
        .feat_d   (feat_d),
        .feat_e   (feat_e),
        .feat_f   (feat_f),
        .feat_g   (feat_g),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err)
`ifdef TNN_PACK_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [13:0] f;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        prev_mv = 1'b0;
    logic [13:0] w_feats;

    assign w_feats = {feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g};

    // Hand-computed expected vectors {a..g}
    localparam logic [13:0] V1 = {2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    localparam logic [13:0] V2 = {2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    localparam logic [13:0] V3 = {2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_vec(input logic [13:0] f);
        exp_t e;
        e.is_err = 1'b0;
        e.f      = f;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.f      = '0;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: pops on each new vector and on each error pulse.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (m_valid === 1'b1 && prev_mv !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vector", {2'b0, w_feats}, 16'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("vector_kind", {15'd0, 1'b0}, {15'd0, e.is_err});
                    chk("vector_feats", {2'b0, w_feats}, {2'b0, e.f});
                end
            end
            if (frame_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_err", 16'd1, 16'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err_kind", 16'd1, {15'd0, e.is_err});
                end
            end
        end
        prev_mv <= m_valid;
    end

    // Drives one beat and returns just after the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("s_ready_timeout", 16'd0, 16'd1);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [55:0] b);
        for (int i = 0; i < 7; i++)
            send(b[55-8*i -: 8], i == 6);
        idle();
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", {15'd0, s_ready}, 16'd0);
        chk("rst_m_valid", {15'd0, m_valid}, 16'd0);
        chk("rst_frame_err", {15'd0, frame_err}, 16'd0);
        chk("rst_feats", {2'b0, w_feats}, 16'd0);
`ifdef TNN_PACK_ERRCNT_EN
        chk("rst_err_cnt", {8'd0, err_cnt}, 16'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", {15'd0, s_ready}, 16'd1);

        // Threshold boundaries, consumer always ready
        m_ready = 1'b1;
        push_vec(V1);
        send_frame({8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd192, 8'd255});
        chk("latency_m_valid", {15'd0, m_valid}, 16'd1);
        chk("hold_s_ready", {15'd0, s_ready}, 16'd0);
        @(negedge clk);
        chk("after_hs_m_valid", {15'd0, m_valid}, 16'd0);
        chk("after_hs_s_ready", {15'd0, s_ready}, 16'd1);

        // Back-pressure: held for 5 cycles, handshake on the 6th
        m_ready = 1'b0;
        push_vec(V2);
        send_frame({8'd200, 8'd10, 8'd130, 8'd70, 8'd255, 8'd0, 8'd191});
        for (int k = 0; k < 5; k++) begin
            chk("bp_s_ready", {15'd0, s_ready}, 16'd0);
            chk("bp_m_valid", {15'd0, m_valid}, 16'd1);
            chk("bp_feats", {2'b0, w_feats}, {2'b0, V2});
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_s_ready", {15'd0, s_ready}, 16'd1);
        chk("bp_release_m_valid", {15'd0, m_valid}, 16'd0);
        chk("bp_feats_kept", {2'b0, w_feats}, {2'b0, V2});

        // Short frame: s_last on 3rd beat
        push_err();
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b1);
        idle();
        chk("short_frame_err", {15'd0, frame_err}, 16'd1);
        chk("short_no_m_valid", {15'd0, m_valid}, 16'd0);
        @(negedge clk);
        chk("short_err_one_pulse", {15'd0, frame_err}, 16'd0);
        push_vec(V3);
        send_frame({8'd65, 8'd129, 8'd193, 8'd1, 8'd64, 8'd128, 8'd192});

        // Long frame: 10 beats, s_last on the 10th
        push_err();
        for (int i = 1; i <= 10; i++) begin
            send(8'(i * 20), i == 10);
            if (i == 7) begin
                @(negedge clk);
                s_valid = 1'b0;
                chk("long_frame_err", {15'd0, frame_err}, 16'd1);
            end
        end
        idle();
        chk("long_no_m_valid", {15'd0, m_valid}, 16'd0);
        push_vec(V1);
        send_frame({8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd192, 8'd255});

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) send(8'd255, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", {15'd0, s_ready}, 16'd0);
        chk("midrst_m_valid", {15'd0, m_valid}, 16'd0);
        chk("midrst_frame_err", {15'd0, frame_err}, 16'd0);
        chk("midrst_feats", {2'b0, w_feats}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_s_ready", {15'd0, s_ready}, 16'd1);
        push_vec(V3);
        send_frame({8'd65, 8'd129, 8'd193, 8'd1, 8'd64, 8'd128, 8'd192});
        repeat (3) @(negedge clk);

`ifdef TNN_PACK_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            push_err();
            send(8'd5, 1'b1);
        end
        idle();
        repeat (3) @(negedge clk);
        chk("err_cnt_sat", {8'd0, err_cnt}, 16'd255);
        repeat (5) @(negedge clk);
        chk("err_cnt_hold", {8'd0, err_cnt}, 16'd255);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tnn_feature_packer.md
TNN_FEATURE_PACKER -- requirements
Module: tnn_feature_packer

Interface
REQ-001 SHALL have parameter T0, default 8'd64, meaning lower quantisation threshold.
REQ-002 SHALL have parameter T1, default 8'd128, meaning middle threshold; T0 < T1 < T2 required.
REQ-003 SHALL have parameter T2, default 8'd192, meaning upper threshold.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_valid  input  1  raw feature beat valid.
REQ-007 SHALL have port s_ready  output  1  packer accepts beat.
REQ-008 SHALL have port s_data  input  8  raw unsigned feature value.
REQ-009 SHALL have port s_last  input  1  marks 7th (final) feature of a frame.
REQ-010 SHALL have ports feat_a..feat_g  output  2 each  quantised features 0..6, wired to the 2-bit classifier inputs a..g.
REQ-011 SHALL have port m_valid  output  1  packed vector valid.
REQ-012 SHALL have port m_ready  input  1  classifier stage consumes vector.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-014 SHALL accept a beat only on the cycle where s_valid and s_ready are both 1.
REQ-015 SHALL quantise each accepted beat as q = 3 if s_data>=T2, 2 if >=T1, 1 if >=T0, else 0 (boundary values map upward, e.g. 64->1, 63->0, 255->3).
REQ-016 SHALL store beat index i (0..6, in acceptance order) into feat_a (i=0) through feat_g (i=6).
REQ-017 SHALL implement states COLLECT, HOLD, DROP.
REQ-018 COLLECT: s_ready=1, m_valid=0; 3-bit index counts accepted beats.
REQ-019 COLLECT, index 6 accepted with s_last=1: register all seven quantised values into feat_*, set m_valid=1 on the next cycle (latency 1 cycle from final beat), index->0, go HOLD.
REQ-020 COLLECT, beat accepted with s_last=1 and index<6: discard partial frame, index->0, pulse frame_err next cycle, stay COLLECT.
REQ-021 COLLECT, index 6 accepted with s_last=0: discard frame, pulse frame_err next cycle, go DROP.
REQ-022 DROP: s_ready=1, beats discarded; beat accepted with s_last=1 -> COLLECT, index 0, no further err pulse.
REQ-023 HOLD: s_ready=0, m_valid=1, feat_* stable; when m_ready=1 go COLLECT with m_valid=0 on next cycle.
REQ-024 SHALL have no combinational path from m_ready to s_ready or from s_valid to m_valid; all outputs registered except s_ready (state decode only).
REQ-025 Peak throughput SHALL be one frame per 8 cycles (7 beats + 1 HOLD handshake cycle).
REQ-026 feat_* SHALL change only on the REQ-019 load; they hold the last valid vector otherwise.

Reset
REQ-027 On rst=1 at a clock edge: state=COLLECT, index=0, m_valid=0, frame_err=0, feat_a..feat_g=2'b00; any partial or held frame is discarded.
REQ-028 s_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.

Configuration
REQ-029 Macro TNN_PACK_ERRCNT_EN SHALL, when defined, add output err_cnt (8 bits, reset 0) counting frame_err pulses, saturating at 255 (no wrap).
REQ-030 Without TNN_PACK_ERRCNT_EN the err_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Beats 0,63,64,127,128,192,255 (last on 7th), m_ready=1 -> m_valid 1 cycle after 7th beat, feat_a..g = 0,0,1,1,2,3,3.
REQ-032 Valid frame, m_ready=0 for 5 cycles -> s_ready=0, m_valid and feat_* stable for 5 cycles; handshake on 6th -> s_ready=1 next cycle.
REQ-033 s_last on 3rd beat -> frame_err one pulse, no m_valid; following good frame packs correctly.
REQ-034 10 beats, s_last only on 10th -> frame_err one pulse after 7th beat, beats 8-10 dropped, next frame good.
REQ-035 rst asserted after 4 beats -> all outputs reset; next 7-beat frame packs with no residue from old beats.
REQ-036 With TNN_PACK_ERRCNT_EN, 300 malformed frames -> err_cnt=255 and holds.
